// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the core's CEN/WEN/OEN/A/D data-memory interface. It is a
//   single-port word memory with a programmable access latency. The core sees
//   'stall' while an access is pending and a one-cycle 'done' pulse when it
//   completes. With LATENCY=0 every access completes on its accepting edge,
//   which suits the single-cycle core.
//
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous, active-low reset
//     CEN    chip enable, active-low (0 = request present)
//     WEN    0 = write, 1 = read; sampled together with CEN
//     OEN    output enable, active-low; 1 forces Q to zero
//     A      word address
//     D      write data
//     Q      read data: registered, then gated by OEN
//     stall  high while an accepted access is pending
//     done   one-cycle pulse when an access commits
module dmem_responder #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CEN,
   input  logic              WEN,
   input  logic              OEN,
   input  logic [ADDR_W-1:0] A,
   input  logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] Q,
   output logic              stall,
   output logic              done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                wen_q;
   logic [DATA_W-1:0]   readData_q;
   logic                done_q;
   logic [DEPTH-1:0]    valid_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                commitNow;
   logic                commitWen;
   logic [ADDR_W-1:0]   commitAddr;
   logic [DATA_W-1:0]   commitData;

   // Select what gets committed this edge. With zero latency the live request
   // commits on its accepting edge. Otherwise the latched request commits once
   // the countdown in WAIT has expired.
   generate
      if (LATENCY == 0) begin : gZeroLat
         always_comb begin
            commitNow  = (state_q == IDLE) && !CEN;
            commitWen  = WEN;
            commitAddr = A;
            commitData = D;
         end
      end else begin : gMultiLat
         always_comb begin
            commitNow  = (state_q == WAIT) && (cnt_q == 4'd0);
            commitWen  = wen_q;
            commitAddr = addr_q;
            commitData = data_q;
         end
      end
   endgenerate

   // Control FSM plus every register that needs a reset value. The valid bits
   // let never-written words read as zero even though the array has no reset.
   // Requests arriving while in WAIT are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         data_q     <= '0;
         wen_q      <= 1'b1;
         readData_q <= '0;
         done_q     <= 1'b0;
         valid_q    <= '0;
      end else begin
         done_q <= commitNow;
         case (state_q)
            IDLE: begin
               if (!CEN) begin
                  addr_q <= A;
                  data_q <= D;
                  wen_q  <= WEN;
                  if (LATENCY != 0) begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (commitNow) begin
            if (!commitWen) begin
               valid_q[commitAddr] <= 1'b1;
            end else begin
               readData_q <= valid_q[commitAddr] ? mem[commitAddr] : '0;
            end
         end
      end
   end

   // The data array has no reset. Writes are gated by rst so that a
   // zero-latency request presented during reset cannot land in the array.
   always_ff @(posedge clk) begin
      if (rst && commitNow && !commitWen) begin
         mem[commitAddr] <= commitData;
      end
   end

   assign stall = (state_q == WAIT);
   assign done  = done_q;
   assign Q     = OEN ? '0 : readData_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Drives two responders: one with LATENCY=2 and one with LATENCY=0. Each
//   has its own CEN, and the other inputs are shared. Directed table vectors
//   and hand sequences cover the corner cases. Random accesses are then
//   checked against a word/valid array model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        cen0, cen2, wen, oen;
   logic [6:0]  a;
   logic [31:0] d;
   logic [31:0] q0, q2;
   logic        stall0, stall2, done0, done2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          isWr;
      logic [6:0]  addr;
      logic [31:0] data;
      logic [31:0] expQ;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] modelMem   [2][128];
   bit          modelValid [2][128];

   dmem_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .CEN(cen2), .WEN(wen), .OEN(oen),
      .A(a), .D(d), .Q(q2), .stall(stall2), .done(done2)
   );

   dmem_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .CEN(cen0), .WEN(wen), .OEN(oen),
      .A(a), .D(d), .Q(q0), .stall(stall0), .done(done0)
   );

   always #5 clk = ~clk;

   // Compare one value and report it if it differs.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic getDone(input int lat);
      return (lat == 0) ? done0 : done2;
   endfunction

   function automatic logic getStall(input int lat);
      return (lat == 0) ? stall0 : stall2;
   endfunction

   function automatic logic [31:0] getQ(input int lat);
      return (lat == 0) ? q0 : q2;
   endfunction

   // Reference model: a plain word array with a written flag per word.
   function automatic logic [31:0] modelRead(input int lat, input logic [6:0] addr);
      int idx = (lat == 0) ? 0 : 1;
      return modelValid[idx][addr] ? modelMem[idx][addr] : 32'h0;
   endfunction

   task automatic modelWrite(input int lat, input logic [6:0] addr, input logic [31:0] data);
      int idx = (lat == 0) ? 0 : 1;
      modelMem[idx][addr]   = data;
      modelValid[idx][addr] = 1'b1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 128; j++)
            modelValid[i][j] = 1'b0;
   endtask

   // Issue one access on the chosen responder. Wait (bounded) for done and
   // count the stall cycles on the way. The call returns in the done cycle,
   // so a following call issues its request back-to-back.
   task automatic applyStimulus(input int lat, input bit isWr, input logic [6:0] addr,
                                input logic [31:0] data, input bit chkQ,
                                input logic [31:0] expQ, input string name);
      int stallCnt = 0;
      bit seen = 1'b0;
      @(negedge clk);
      if (lat == 0) cen0 = 1'b0; else cen2 = 1'b0;
      wen = ~isWr;
      a   = addr;
      d   = data;
      @(posedge clk); #1;
      cen0 = 1'b1;
      cen2 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (getDone(lat)) begin
            seen = 1'b1;
            break;
         end
         if (getStall(lat)) stallCnt++;
         @(posedge clk); #1;
      end
      checkOutput({name, "_done"}, 32'(seen), 32'd1);
      checkOutput({name, "_stall"}, 32'(stallCnt), 32'(lat));
      if (chkQ) checkOutput({name, "_q"}, getQ(lat), expQ);
   endtask

   initial begin
      int   lat;
      bit   isWr;
      logic [6:0]  ra;
      logic [31:0] rd;
      bit   seen;

      vecs[0] = '{1'b0, 7'd5,   32'h0,        32'h0};
      vecs[1] = '{1'b1, 7'd3,   32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b0, 7'd3,   32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b1, 7'd127, 32'h1,        32'h0};
      vecs[4] = '{1'b1, 7'd0,   32'h2,        32'h0};
      vecs[5] = '{1'b0, 7'd127, 32'h0,        32'h1};
      vecs[6] = '{1'b0, 7'd0,   32'h0,        32'h2};
      vecs[7] = '{1'b0, 7'd3,   32'h0,        32'hDEADBEEF};

      modelReset();
      rst = 1'b0; cen0 = 1'b1; cen2 = 1'b1; wen = 1'b1; oen = 1'b0; a = '0; d = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_stall2", 32'(stall2), 32'd0);
      checkOutput("rst_done2",  32'(done2),  32'd0);
      checkOutput("rst_q2",     q2,          32'h0);
      checkOutput("rst_stall0", 32'(stall0), 32'd0);
      checkOutput("rst_q0",     q0,          32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Directed vectors on LATENCY=2, issued back-to-back.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(2, vecs[i].isWr, vecs[i].addr, vecs[i].data, !vecs[i].isWr,
                       vecs[i].expQ, $sformatf("vec%0d", i));
         if (vecs[i].isWr) modelWrite(2, vecs[i].addr, vecs[i].data);
      end
      // Q must hold after done drops.
      @(posedge clk); #1;
      checkOutput("hold_done", 32'(done2), 32'd0);
      checkOutput("hold_q",    q2,         32'hDEADBEEF);

      // A write attempt held on the bus during the stall must be ignored.
      @(negedge clk);
      cen2 = 1'b0; wen = 1'b1; a = 7'd5;
      @(posedge clk); #1;
      wen = 1'b0; a = 7'd9; d = 32'h55;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done2) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      cen2 = 1'b1;
      checkOutput("ign_done", 32'(seen), 32'd1);
      applyStimulus(2, 1'b0, 7'd9, 32'h0, 1'b1, 32'h0, "ign_read9");

      // A reset during a pending write aborts the write.
      applyStimulus(2, 1'b0, 7'd3, 32'h0, 1'b1, 32'hDEADBEEF, "pre_rst_read");
      @(negedge clk);
      cen2 = 1'b0; wen = 1'b0; a = 7'd7; d = 32'h77;
      @(posedge clk); #1;
      cen2 = 1'b1;
      checkOutput("abort_pending", 32'(stall2), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("abort_stall", 32'(stall2), 32'd0);
      checkOutput("abort_done",  32'(done2),  32'd0);
      checkOutput("abort_q",     q2,          32'h0);
      @(posedge clk); #1;
      checkOutput("abort_done2", 32'(done2),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      applyStimulus(2, 1'b0, 7'd7, 32'h0, 1'b1, 32'h0, "abort_read7");

      // OEN gating of Q.
      applyStimulus(2, 1'b1, 7'd3, 32'hDEADBEEF, 1'b0, 32'h0, "oen_wr");
      modelWrite(2, 7'd3, 32'hDEADBEEF);
      oen = 1'b1;
      applyStimulus(2, 1'b0, 7'd3, 32'h0, 1'b1, 32'h0, "oen_hi");
      oen = 1'b0;
      #1;
      checkOutput("oen_lo", q2, 32'hDEADBEEF);

      // Zero-latency responder: done in the cycle after the request, no stall.
      applyStimulus(0, 1'b1, 7'd3,   32'hDEADBEEF, 1'b0, 32'h0, "l0_wr3");
      applyStimulus(0, 1'b0, 7'd3,   32'h0, 1'b1, 32'hDEADBEEF, "l0_rd3");
      applyStimulus(0, 1'b1, 7'd127, 32'h1, 1'b0, 32'h0, "l0_wr127");
      applyStimulus(0, 1'b0, 7'd0,   32'h0, 1'b1, 32'h0, "l0_rd0");
      applyStimulus(0, 1'b0, 7'd127, 32'h0, 1'b1, 32'h1, "l0_rd127");
      modelWrite(0, 7'd3, 32'hDEADBEEF);
      modelWrite(0, 7'd127, 32'h1);

      // Random accesses on both responders against the array model.
      for (int i = 0; i < 80; i++) begin
         lat  = ($urandom_range(0, 1) == 0) ? 0 : 2;
         isWr = 1'($urandom_range(0, 1));
         ra   = 7'($urandom_range(0, 127));
         rd   = $urandom;
         if (isWr) begin
            applyStimulus(lat, 1'b1, ra, rd, 1'b0, 32'h0, $sformatf("rnd%0d_wr", i));
            modelWrite(lat, ra, rd);
         end else begin
            applyStimulus(lat, 1'b0, ra, 32'h0, 1'b1, modelRead(lat, ra), $sformatf("rnd%0d_rd", i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
